// File: rtl/hub75_row_shifter.sv
// HUB-75 row shifter: reads one row pair from the line buffer and scans it
// out one bit plane at a time with binary-weighted display intervals.
module hub75_row_shifter #(
    parameter int width          = 64,
    parameter int color_depth    = 8,
    parameter int oe_base_cycles = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  y,
    input  logic        bank,
    output logic        is_idle,
    output logic [6:0]  read_address,
    input  logic [47:0] read_data,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        r2,
    output logic        g2,
    output logic        b2,
    output logic [4:0]  abcde,
    output logic        clk,
    output logic        lat,
    output logic        oe
);

    localparam int cnt_w   = $clog2(oe_base_cycles << (color_depth - 1)) + 1;
    localparam int plane_w = (color_depth > 1) ? $clog2(color_depth) : 1;
    localparam logic [5:0] last_x = 6'(width - 1);
    localparam logic [plane_w-1:0] last_plane = plane_w'(color_depth - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DISPLAY
    } state_t;

    state_t             state;
    logic [plane_w-1:0] plane;
    logic [5:0]         x;
    logic [cnt_w-1:0]   count;
    logic [4:0]         y_q;
    logic               bank_q;
    logic [5:0]         bits;

    // One bit of each colour byte, ordered {r1, g1, b1, r2, g2, b2}
    always_comb begin
        bits = '0;
        for (int c = 0; c < 6; c++) begin
            bits[c] = read_data[8 * c + int'(plane)];
        end
    end

    // Outputs are registered; address 0 is issued on entry to PREFETCH so the
    // first SHIFT_LO sees its data after the one-cycle buffer latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            is_idle      <= 1'b1;
            read_address <= '0;
            {r1, g1, b1, r2, g2, b2} <= '0;
            abcde        <= '0;
            clk          <= 1'b0;
            lat          <= 1'b0;
            oe           <= 1'b1;
            plane        <= '0;
            x            <= '0;
            count        <= '0;
            y_q          <= '0;
            bank_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    clk <= 1'b0;
                    lat <= 1'b0;
                    oe  <= 1'b1;
                    if (start) begin
                        y_q          <= y;
                        bank_q       <= bank;
                        plane        <= '0;
                        x            <= '0;
                        read_address <= {bank, 6'd0};
                        is_idle      <= 1'b0;
                        state        <= PREFETCH;
                    end
                end
                PREFETCH: begin
                    clk          <= 1'b0;
                    lat          <= 1'b0;
                    oe           <= 1'b1;
                    read_address <= {bank_q, 6'd0};
                    state        <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    clk <= 1'b0;
                    {r1, g1, b1, r2, g2, b2} <= bits;
                    if (x != last_x) begin
                        read_address <= {bank_q, x + 6'd1};
                    end
                    state <= SHIFT_HI;
                end
                SHIFT_HI: begin
                    clk <= 1'b1;
                    if (x == last_x) begin
                        state <= LATCH;
                    end else begin
                        x     <= x + 6'd1;
                        state <= SHIFT_LO;
                    end
                end
                LATCH: begin
                    lat   <= 1'b1;
                    clk   <= 1'b0;
                    oe    <= 1'b1;
                    abcde <= y_q;
                    count <= cnt_w'(oe_base_cycles << plane);
                    state <= DISPLAY;
                end
                DISPLAY: begin
                    lat   <= 1'b0;
                    oe    <= (count == '0);
                    count <= count - cnt_w'(1);
                    if (count <= cnt_w'(1)) begin
                        if (plane == last_plane) begin
                            is_idle <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            plane        <= plane + plane_w'(1);
                            x            <= '0;
                            read_address <= {bank_q, 6'd0};
                            state        <= PREFETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_row_shifter.sv
// Directed bench for hub75_row_shifter with a 1-cycle-latency line buffer model.
module tb_hub75_row_shifter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  y = '0;
    logic        bank = 1'b0;
    logic        is_idle;
    logic [6:0]  read_address;
    logic [47:0] read_data = '0;
    logic        r1, g1, b1, r2, g2, b2;
    logic [4:0]  abcde;
    logic        clk, lat, oe;

    int checks = 0;
    int errors = 0;
    int mode = 0;

    hub75_row_shifter dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .y(y),
        .bank(bank),
        .is_idle(is_idle),
        .read_address(read_address),
        .read_data(read_data),
        .r1(r1),
        .g1(g1),
        .b1(b1),
        .r2(r2),
        .g2(g2),
        .b2(b2),
        .abcde(abcde),
        .clk(clk),
        .lat(lat),
        .oe(oe)
    );

    always #5 clock = ~clock;

    // Buffer contents: constant pattern (mode 0) or address-dependent (mode 1)
    function automatic logic [47:0] word(input logic [6:0] a);
        logic [7:0] v;
        v = {1'b0, a};
        if (mode == 0) return 48'hFF00AA550FF0;
        return {v * 8'd5, v ^ 8'h3C, v, ~v, v + 8'd17, {v[3:0], v[7:4]}};
    endfunction

    always @(posedge clock) read_data <= word(read_address);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_row(input logic [4:0] ry, input logic rb,
                          input int busy_at);
        int n, first_clk, rise_idx, lats, run, nr, p;
        int pix_err, oe_err, lat_err, abc_err;
        int runs[8];
        logic [5:0] first_bits[8];
        logic [6:0] amin, amax;
        logic [5:0] got, exp;
        logic [47:0] w;
        logic pclk;
        first_clk = -1; rise_idx = 0; lats = 0; run = 0; nr = 0;
        pix_err = 0; oe_err = 0; lat_err = 0; abc_err = 0;
        for (int i = 0; i < 8; i++) begin
            runs[i] = 0;
            first_bits[i] = '0;
        end
        start = 1'b1; y = ry; bank = rb;
        @(posedge clock); #1;
        start = 1'b0;
        check("idle_drop", is_idle, 0);
        check("oe_gap", oe, 1);
        n = 0;
        pclk = clk;
        amin = read_address;
        amax = read_address;
        while (!is_idle && n < 5000) begin
            @(posedge clock); #1;
            n++;
            if (n == busy_at) begin
                start = 1'b1; y = 5'd9; bank = ~rb;
            end else begin
                start = 1'b0;
            end
            if (clk && first_clk < 0) first_clk = n;
            if (read_address < amin) amin = read_address;
            if (read_address > amax) amax = read_address;
            if (clk && !pclk) begin
                w = word({rb, 6'(rise_idx)});
                p = lats;
                exp = {w[40+p], w[32+p], w[24+p], w[16+p], w[8+p], w[p]};
                got = {r1, g1, b1, r2, g2, b2};
                if (rise_idx == 0 && lats < 8) first_bits[lats] = got;
                if (got !== exp) pix_err++;
                if (!oe) oe_err++;
                rise_idx++;
            end
            pclk = clk;
            if (lat) begin
                lats++;
                if (clk || !oe || rise_idx != 64) lat_err++;
                if (abcde !== ry) abc_err++;
                rise_idx = 0;
            end
            if (!oe) begin
                if (lats == 0) oe_err++;
                run++;
            end else if (run > 0) begin
                if (nr < 8) runs[nr] = run;
                nr++;
                run = 0;
            end
        end
        if (run > 0) begin
            if (nr < 8) runs[nr] = run;
            nr++;
        end
        start = 1'b0;
        check("row_len", n, 2060);
        check("first_clk", first_clk, 3);
        check("lat_count", lats, 8);
        check("lat_shape", lat_err, 0);
        check("pixels", pix_err, 0);
        check("oe_blank", oe_err, 0);
        check("abcde_lat", abc_err, 0);
        check("abcde_end", abcde, ry);
        check("run_count", nr, 8);
        for (int i = 0; i < 8; i++) check("oe_run", runs[i], 4 << i);
        check("addr_lo", amin, {rb, 6'd0});
        check("addr_hi", amax, {rb, 6'd63});
        if (mode == 0) begin
            check("plane0_bits", first_bits[0], 6'b100110);
            check("plane7_bits", first_bits[7], 6'b101001);
        end
    endtask

    task automatic abort_row();
        start = 1'b1; y = 5'd3; bank = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (333) @(posedge clock);
        #1;
        check("busy_pre_rst", is_idle, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_oe", oe, 1);
        check("abort_clk", clk, 0);
        check("abort_lat", lat, 0);
        check("abort_idle", is_idle, 1);
        check("abort_addr", read_address, 0);
        check("abort_abcde", abcde, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom_range(0, 1));
            y = 5'($urandom);
            bank = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            check("rst_idle", is_idle, 1);
            check("rst_oe", oe, 1);
            check("rst_lat", lat, 0);
            check("rst_clk", clk, 0);
            check("rst_addr", read_address, 0);
            check("rst_abcde", abcde, 0);
            check("rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock); #1;
        check("idle_after_rst", is_idle, 1);

        mode = 0;
        do_row(5'd5, 1'b1, -1);
        do_row(5'd5, 1'b1, 450);

        mode = 1;
        abort_row();
        do_row(5'd7, 1'b0, -1);

        do_row(5'd5, 1'b1, -1);
        do_row(5'd12, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75_row_shifter.md
# hub75_row_shifter

Downstream stage of the row controller. On each `start` pulse it reads one 64-pixel row pair (upper and lower half-panel) from the dual-bank line buffer, drives it onto the HUB-75 connector one bit plane at a time, and shows each plane for a binary-weighted interval, giving 8-bit-per-channel colour depth. It reports `is_idle` back to the controller, which uses it to step the row counters.

## Interface
Parameters:
- `width`, 64: pixels per row; must be a power of two, ≤ 64.
- `color_depth`, 8: bits per colour channel, which is also the number of bit planes.
- `oe_base_cycles`, 4: display time of plane 0, in clocks; plane p is shown for `oe_base_cycles << p`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to display one row; accepted only in IDLE.
- `y`  in  5  row address, sampled when `start` is accepted.
- `bank`  in  1  line-buffer half to read, sampled when `start` is accepted.
- `is_idle`  out  1  high in IDLE.
- `read_address`  out  7  line-buffer address, `{bank, x[5:0]}`.
- `read_data`  in  48  line-buffer data, valid 1 clock after the address is presented.
  - Bit layout: `{r1[47:40], g1[39:32], b1[31:24], r2[23:16], g2[15:8], b2[7:0]}`.
- `r1`, `g1`, `b1`, `r2`, `g2`, `b2`  out  1 each  panel colour data.
- `abcde`  out  5  panel row select.
- `clk`  out  1  panel shift clock.
- `lat`  out  1  panel latch.
- `oe`  out  1  panel output enable, active-low (1 = blanked).

## Operation
- All panel outputs are registered.
- Reset values:
  - `oe`=1; `lat`=0; `clk`=0.
  - All colour outputs = 0; `abcde`=0; `read_address`=0.
  - `is_idle`=1; state = IDLE; `plane`=0; `x`=0.
- States:
  - **IDLE**
    - On `start`: latch `y` and `bank`, set `plane`=0 and `x`=0, go to PREFETCH.
    - Otherwise remain in IDLE.
  - **PREFETCH** (1 cycle)
    - `read_address` = `{bank, 0}`.
    - Go to SHIFT_LO.
  - **SHIFT_LO** (1 cycle)
    - `clk`=0.
    - Each colour output takes bit `plane` of its byte in `read_data`.
    - `read_address` advances to `x+1`; it is not advanced past `width-1`.
    - Go to SHIFT_HI.
  - **SHIFT_HI** (1 cycle)
    - `clk`=1.
    - If `x`=`width-1`, go to LATCH.
    - Otherwise `x`++ and go to SHIFT_LO.
  - **LATCH** (1 cycle)
    - `lat`=1, `clk`=0, `oe`=1.
    - `abcde` ← latched `y`.
    - Load the display counter with `oe_base_cycles << plane`.
    - Go to DISPLAY.
  - **DISPLAY**
    - `oe`=0 while the counter is nonzero; the counter decrements each cycle.
    - When the counter reaches 1:
      - if `plane` = `color_depth-1`, go to IDLE;
      - otherwise `plane`++, `x`=0, go to PREFETCH.
- `oe` is 1 in every state except DISPLAY, so the panel is blanked while shifting and latching and while `abcde` changes.
- `abcde` changes only in LATCH. It holds its value in IDLE, so it is not glitched between rows.
- `start` while not in IDLE is ignored; it is neither queued nor allowed to corrupt the latched `y`/`bank`.
- `reset` takes priority over `start` in the same cycle.
- A `reset` mid-row aborts the row immediately. The next cycle shows the reset values, so `oe`=1 with no partial display.
- Display counter width is `$clog2(oe_base_cycles << (color_depth-1)) + 1`, with no overflow for the default parameters (max 512).

## Timing
- Outputs lag the state decision by 1 cycle (registered).
- `start` accepted at cycle 0 gives:
  - `is_idle`=0 from cycle 1;
  - first `clk` rise at cycle 3.
- `read_data` for pixel x is sampled in the SHIFT_LO that follows the cycle in which address x was presented (1-cycle RAM latency).
- Per plane p: 1 (PREFETCH) + 2·`width` (shift) + 1 (LATCH) + (`oe_base_cycles << p`) (DISPLAY) cycles.
- Full row with defaults: 8·130 + 4·255 = 2060 cycles from `start` to `is_idle`=1.
- `lat` is high for exactly 1 cycle per plane, with `clk`=0 and `oe`=1 in that cycle.
- `clk` duty is 50%, period 2 cycles; data is stable for 1 full cycle before each rising edge.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with random `start` -> all outputs at reset values, `oe`=1, `is_idle`=1, no `clk` edges.
- **Single row, pixel bit extraction.** `y`=5, `bank`=1, buffer word x = `{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hF0}` for all x -> `read_address` sweeps 64..127.
  - Plane 0: r1=1, g1=0, b1=0, r2=1, g2=1, b2=0 on every one of 64 `clk` rises.
  - Plane 7: r1=1, b1=1, g2=0, b2=1.
  - `abcde`=5 after the first `lat`.
- **Plane weighting.** Defaults -> `oe` low runs of 4, 8, 16 … 512 cycles, in that order; exactly 8 `lat` pulses; `is_idle` rises 2060 cycles after `start`.
- **Start while busy.** Pulse `start` with `y`=9 during plane 3 -> ignored; `abcde` stays 5; total length unchanged.
- **Reset mid-shift.** Assert `reset` at pixel 30 of plane 2 -> next cycle `oe`=1, `clk`=0, `lat`=0, `is_idle`=1. A following `start` runs a full, correct row.
- **Back-to-back rows.** Assert `start` in the cycle `is_idle` rises, `bank` toggling -> no dead cycle beyond IDLE. `oe` stays high from the end of DISPLAY to the first DISPLAY of the next row.
